// File: rtl/mc_control_pkg.sv
// Shared types and encodings for the multicycle ARM control unit.
package mc_control_pkg;

  localparam int MC_STATE_W = 4;

  typedef enum logic [MC_STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

endpackage

// File: rtl/mc_alu_dec.sv
// ALU operation and flag-write decode; Funct here is Instr[24:20] (cmd and S),
// the I bit is consumed by the state machine instead.
module mc_alu_dec
  import mc_control_pkg::*;
(
  input  logic       ALUOp,
  input  logic [4:0] Funct,
  output logic [1:0] ALUControl,
  output logic [1:0] FlagW
);

  logic [3:0] cmd;
  logic       s_bit;

  assign cmd   = Funct[4:1];
  assign s_bit = Funct[0];

  always_comb begin
    ALUControl = ALU_ADD;
    FlagW      = 2'b00;
    if (ALUOp) begin
      unique case (cmd)
        CMD_ADD: begin
          ALUControl = ALU_ADD;
          FlagW      = {s_bit, s_bit};
        end
        CMD_SUB: begin
          ALUControl = ALU_SUB;
          FlagW      = {s_bit, s_bit};
        end
        CMD_AND: begin
          ALUControl = ALU_AND;
          FlagW      = {s_bit, 1'b0};
        end
        CMD_ORR: begin
          ALUControl = ALU_ORR;
          FlagW      = {s_bit, 1'b0};
        end
        // Unsupported commands fall back to ADD and leave the flags alone.
        default: begin
          ALUControl = ALU_ADD;
          FlagW      = 2'b00;
        end
      endcase
    end
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle ARM control unit: Moore sequencer plus decode of the raw
// PC/register/memory/flag write requests that condition logic later qualifies.
module mc_control_fsm #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         Op,
  input  logic [5:0]         Funct,
  input  logic [3:0]         Rd,
  output logic               IRWrite,
  output logic               NextPC,
  output logic               AdrSrc,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ImmSrc,
  output logic [1:0]         RegSrc,
  output logic [1:0]         ALUControl,
  output logic [1:0]         FlagW,
  output logic               PCS,
  output logic               RegW,
  output logic               MemW,
  output logic [STATE_W-1:0] state_o
);

  import mc_control_pkg::*;

  state_t     state_q, state_d;
  logic       irwrite_raw, nextpc_raw, regw_raw, memw_raw, branch_raw;
  logic       alu_op;
  logic [1:0] flagw_raw;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    irwrite_raw = 1'b0;
    nextpc_raw  = 1'b0;
    regw_raw    = 1'b0;
    memw_raw    = 1'b0;
    branch_raw  = 1'b0;
    alu_op      = 1'b0;
    AdrSrc      = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ResultSrc   = 2'b00;
    unique case (state_q)
      S_FETCH: begin
        state_d     = S_DECODE;
        irwrite_raw = 1'b1;
        nextpc_raw  = 1'b1;
        ALUSrcA     = 1'b1;
        ALUSrcB     = 2'b10;
        ResultSrc   = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (Op == OP_MEM)     state_d = S_MEMADR;
        else if (Op == OP_DP) state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
        else if (Op == OP_BR) state_d = S_BRANCH;
        else                  state_d = S_FETCH;
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
        state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        regw_raw  = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        memw_raw = 1'b1;
        state_d  = S_FETCH;
      end
      S_EXECUTER: begin
        alu_op  = 1'b1;
        state_d = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_op  = 1'b1;
        ALUSrcB = 2'b01;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regw_raw = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcB    = 2'b01;
        ResultSrc  = 2'b10;
        branch_raw = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  mc_alu_dec u_alu_dec (
    .ALUOp      (alu_op),
    .Funct      (Funct[4:0]),
    .ALUControl (ALUControl),
    .FlagW      (flagw_raw)
  );

  // Write requests are suppressed during reset so an abandoned instruction
  // can never commit architectural state.
  assign IRWrite = irwrite_raw & ~reset;
  assign NextPC  = nextpc_raw & ~reset;
  assign RegW    = regw_raw & ~reset;
  assign MemW    = memw_raw & ~reset;
  assign FlagW   = reset ? 2'b00 : flagw_raw;
  assign PCS     = (branch_raw | (regw_raw & (Rd == 4'hF))) & ~reset;

  assign ImmSrc  = Op;
  assign RegSrc  = {Op == OP_MEM, Op == OP_BR};
  assign state_o = STATE_W'(state_q);

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multicycle ARM control unit; the producer of the PCS/RegW/MemW/FlagW qualifiers that the conditional-execution logic gates with CondEx.
- Decodes the instruction held in the instruction register.
- Sequences each instruction through FETCH/DECODE/execute/writeback cycles with a Moore state machine.
- Drives datapath mux selects and raw write requests every cycle.

Parameters:
- STATE_W, 4, width of the state register and of the debug state output.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- Op  in  2  Instr[27:26]: 00 data-processing, 01 memory, 10 branch, 11 illegal.
- Funct  in  6  Instr[25:20]: [5]=I, [4:1]=cmd, [0]=S (DP) or L (memory).
- Rd  in  4  Instr[15:12].
- IRWrite  out  1  instruction register load.
- NextPC  out  1  unconditional PC update (fetch increment).
- AdrSrc  out  1  memory address select: 0 PC, 1 ALUOut.
- ALUSrcA  out  1  0 register A, 1 PC.
- ALUSrcB  out  2  00 reg B, 01 ExtImm, 10 constant 4.
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult.
- ImmSrc  out  2  equals Op.
- RegSrc  out  2  [0]=(Op==10), [1]=(Op==01).
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR.
- FlagW  out  2  [1] write N,Z; [0] write C,V.
- PCS  out  1  PC-write request, condition-qualified downstream.
- RegW  out  1  register-write request, condition-qualified downstream.
- MemW  out  1  memory-write request, condition-qualified downstream.
- state_o  out  STATE_W  current state, for debug and verification.

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH.
- Transitions:
  - FETCH->DECODE.
  - DECODE: Op=01->MEMADR; Op=00 with Funct[5]=0->EXECUTER; Op=00 with Funct[5]=1->EXECUTEI; Op=10->BRANCH; Op=11->FETCH.
  - MEMADR: Funct[0]=1->MEMREAD, else MEMWRITE.
  - MEMREAD->MEMWB->FETCH.
  - MEMWRITE->FETCH.
  - EXECUTER/EXECUTEI->ALUWB->FETCH.
  - BRANCH->FETCH.
- Per-state outputs (every unlisted output is 0):
  - FETCH: IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUOp=0.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUOp=0.
  - MEMADR: ALUSrcA=0, ALUSrcB=01, ALUOp=0.
  - MEMREAD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemW=1.
  - EXECUTER: ALUSrcA=0, ALUSrcB=00, ALUOp=1.
  - EXECUTEI: ALUSrcA=0, ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=1.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, ALUOp=0, Branch=1.
- ALU decode:
  - ALUOp=0: ALUControl=00, FlagW=00.
  - ALUOp=1, by cmd: 0100 ADD->00, 0010 SUB->01, 0000 AND->10, 1100 ORR->11; any other cmd->00 with FlagW=00.
  - FlagW[1]=S; FlagW[0]=S & (ADD|SUB).
  - FlagW is non-zero only in EXECUTER/EXECUTEI, so flags are written exactly once per instruction.
- PCS = Branch | (RegW & Rd==4'hF). It asserts only in BRANCH, MEMWB and ALUWB.
- ImmSrc and RegSrc are combinational on Op in every state.
- Latencies in cycles: load 5, store 4, DP 4, branch 3, illegal 2.
- Outputs are decoded from the state register plus the current Op/Funct/Rd; there is no output register.
- Reset:
  - reset=1 at a rising edge forces FETCH, including mid-instruction; a partially executed instruction is abandoned.
  - While reset=1, IRWrite, NextPC, RegW, MemW, PCS and FlagW are forced to 0. The selects take their FETCH values once state=FETCH.
  - First fetch occurs in the first cycle with reset=0.
- Op/Funct/Rd must be stable from DECODE through the end of the instruction. The IR is loaded only in FETCH.

Decomposition:
- mc_control_pkg holds:
  - state_t enum, STATE_W-wide; encoding FETCH=0 … BRANCH=9.
  - Op constants OP_DP, OP_MEM, OP_BR.
  - cmd constants CMD_ADD, CMD_SUB, CMD_AND, CMD_ORR.
  - ALUControl constants ALU_ADD, ALU_SUB, ALU_AND, ALU_ORR.
- One sub-module, mc_alu_dec:
  - Inputs: ALUOp, Funct.
  - Outputs: ALUControl, FlagW.
  - Purely combinational.
- The top contains the state register, the next-state logic, the output decode and the PCS logic.

Test Plan:
- Reset then Op=00, Funct=101001 (ADDS imm), Rd=3:
  - states FETCH,DECODE,EXECUTEI,ALUWB,FETCH.
  - EXECUTEI: ALUControl=00, FlagW=11.
  - ALUWB: RegW=1, PCS=0.
- Op=00, Funct=011000 (ORR reg, S=0), Rd=15:
  - EXECUTER: ALUControl=11, FlagW=00.
  - ALUWB: RegW=1, PCS=1.
- Op=01, Funct=011001 (LDR):
  - path MEMADR, MEMREAD, MEMWB.
  - MEMREAD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - Store (Funct[0]=0): MEMWRITE with MemW=1, RegW=0, then FETCH.
- Op=10:
  - BRANCH: PCS=1, ALUSrcB=01, ImmSrc=10, RegSrc[0]=1.
  - Total 3 cycles. Op=11: DECODE->FETCH, no write asserted.
- Assert reset in MEMADR of a store:
  - next edge state=FETCH; MemW never asserted.
  - IRWrite/NextPC stay 0 while reset=1 and go 1 in the first cycle with reset=0.
- Op=00, cmd=0010, S=1 vs cmd=0000, S=1:
  - SUB gives FlagW=11.
  - AND gives FlagW=10, ALUControl=10.
